fm_demod: RTL
=============

FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 Parameter AMP_WIDTH, default 10, sample width, matching the DAC/DDS amplitude bus.
REQ-002 Parameter CNT_WIDTH, default 16, period counter and output width.
REQ-003 Parameter HYST, default 16, hysteresis half-band in LSBs around midscale.
REQ-004 Parameter AVG_LOG2, default 2, log2 of the number of periods averaged per result.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  sample strobe, same role as the DDS enable; all state advances only when en=1.
REQ-008 sample  input  AMP_WIDTH  unsigned offset-binary FM waveform, midscale 2^(AMP_WIDTH-1).
REQ-009 period  output  CNT_WIDTH  measured period in en strobes.
REQ-010 period_valid  output  1  one-clk pulse when period updates.
REQ-011 locked  output  1  high once a valid period has been produced since the last reset or timeout.
REQ-012 timeout  output  1  one-clk pulse when the counter saturates without a crossing.

Function
REQ-013 Thresholds: HI = mid+HYST, LO = mid-HYST; crossings are evaluated only on en=1 cycles.
REQ-014 The FSM shall have the states IDLE, ARMED, HIGH and no others.
REQ-015 IDLE: when sample<LO, go to ARMED with first=1.
REQ-016 ARMED: when sample>HI, a rising crossing occurs and the FSM goes to HIGH.
REQ-017 HIGH: when sample<LO, go to ARMED; samples in [LO,HI] cause no transition in any state.
REQ-018 Counter cnt: on an en cycle with a crossing, raw = cnt+1 and cnt <= 0; on an en cycle without a crossing, cnt <= cnt+1.
REQ-019 The first crossing after IDLE only starts timing (cnt <= 0, first <= 0) and produces no raw period.
REQ-020 Each subsequent crossing yields raw, so crossings N strobes apart give raw=N.
REQ-021 With averaging, raw values are summed into a (CNT_WIDTH+AVG_LOG2)-bit accumulator.
REQ-022 On the 2^AVG_LOG2-th raw value, period <= (sum+raw)>>AVG_LOG2 (truncating), the accumulator clears, and period_valid pulses.
REQ-023 Output latency: period and period_valid are registered and asserted on the clk edge after the en cycle containing the final crossing.
REQ-024 locked is set together with the first period_valid.
REQ-025 Saturation: if cnt reaches 2^CNT_WIDTH-2 on a non-crossing en cycle, timeout pulses and the FSM goes to IDLE.
REQ-026 On saturation, locked clears, the accumulator and average count clear, first=1, and period holds its last value.
REQ-027 A crossing and saturation on the same cycle: the crossing wins and no timeout occurs.
REQ-028 en=0: all state, counters and outputs hold, and pulses do not fire.
REQ-029 period_valid and timeout shall never be asserted on the same cycle.

Reset
REQ-030 On reset=1 at a clk edge: FSM=IDLE, cnt=0, accumulator=0, average count=0, first=1, period=0, period_valid=0, locked=0, timeout=0.
REQ-031 Reset shall override en and abandon any partial average; a reset mid-measurement produces no output pulse.

Configuration
REQ-032 Macro FM_DEMOD_AVG_EN defined: averaging over 2^AVG_LOG2 periods per REQ-021/022.
REQ-033 Macro FM_DEMOD_AVG_EN undefined: no accumulator is built, every raw value goes directly to period with period_valid, and AVG_LOG2 is ignored.

Verification
REQ-034 en every 10 clks; square wave alternating 200/824 with a period of 20 strobes; AVG on, AVG_LOG2=2 -> first period_valid after the 5th rising crossing, period=20, locked=1.
REQ-035 Alternating periods 19,21,19,21 strobes -> period=20; AVG off -> raw outputs 19,21,19,21.
REQ-036 Sample toggling 500/524 (inside ±16 band) for 1000 strobes -> no period_valid; crossings of 480/544 are detected.
REQ-037 CNT_WIDTH=8, constant sample 900 after lock -> timeout pulse at cnt=254, locked=0, period holds, and a new lock needs 1+4 crossings.
REQ-038 reset asserted between the 3rd and 4th crossings -> all outputs 0, no pulse; after release, output follows REQ-034 timing from scratch.
REQ-039 en held 0 for 50 clks mid-period -> measured period unchanged (20).

Source files
------------

// File: rtl/fm_demod.sv
// Zero-crossing FM demodulator: measures the strobe count between rising crossings
// of a hysteresis band and reports it, averaged when FM_DEMOD_AVG_EN is defined.
module fm_demod #(
   parameter int AMP_WIDTH = 10,
   parameter int CNT_WIDTH = 16,
   parameter int HYST      = 16,
   parameter int AVG_LOG2  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [AMP_WIDTH-1:0] sample,
   output logic [CNT_WIDTH-1:0] period,
   output logic                 period_valid,
   output logic                 locked,
   output logic                 timeout,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HIGH  = 2'd2
   } state_t;

   localparam logic [AMP_WIDTH-1:0] LP_MID = {1'b1, {(AMP_WIDTH-1){1'b0}}};
   localparam logic [AMP_WIDTH-1:0] LP_HI  = LP_MID + AMP_WIDTH'(HYST);
   localparam logic [AMP_WIDTH-1:0] LP_LO  = LP_MID - AMP_WIDTH'(HYST);
   // Largest cnt value kept: cnt+1 then still fits in CNT_WIDTH bits.
   localparam logic [CNT_WIDTH-1:0] LP_SAT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

   state_t                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_first;
   logic [CNT_WIDTH-1:0]   r_period;
   logic                   r_period_valid;
   logic                   r_locked;
   logic                   r_timeout;

   logic                   w_below;
   logic                   w_above;
   logic                   w_cross;
   logic                   w_sat;
   logic [CNT_WIDTH-1:0]   w_raw;

`ifdef FM_DEMOD_AVG_EN
   localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] LP_AVG_LAST = '1;

   logic [ACC_W-1:0]       r_acc;
   logic [AVG_LOG2-1:0]    r_avg_cnt;
   logic [ACC_W-1:0]       w_sum;

   assign w_sum = r_acc + ACC_W'(w_raw);
`endif

   assign w_below = (sample < LP_LO);
   assign w_above = (sample > LP_HI);
   // Only an ARMED->HIGH transition counts as a crossing; the band gives hysteresis.
   assign w_cross = en && (r_state == ST_ARMED) && w_above;
   // Timing runs only after the first crossing, so an idle input never times out.
   assign w_sat   = en && !r_first && !w_cross && (r_cnt == LP_SAT);
   assign w_raw   = r_cnt + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_first        <= 1'b1;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_locked       <= 1'b0;
         r_timeout      <= 1'b0;
`ifdef FM_DEMOD_AVG_EN
         r_acc          <= '0;
         r_avg_cnt      <= '0;
`endif
      end else begin
         r_period_valid <= 1'b0;
         r_timeout      <= 1'b0;
         if (en) begin
            if (w_cross) begin
               r_state <= ST_HIGH;
               r_cnt   <= '0;
               r_first <= 1'b0;
               if (!r_first) begin
`ifdef FM_DEMOD_AVG_EN
                  if (r_avg_cnt == LP_AVG_LAST) begin
                     r_period       <= CNT_WIDTH'(w_sum >> AVG_LOG2);
                     r_period_valid <= 1'b1;
                     r_locked       <= 1'b1;
                     r_acc          <= '0;
                     r_avg_cnt      <= '0;
                  end else begin
                     r_acc     <= w_sum;
                     r_avg_cnt <= r_avg_cnt + AVG_LOG2'(1);
                  end
`else
                  r_period       <= w_raw;
                  r_period_valid <= 1'b1;
                  r_locked       <= 1'b1;
`endif
               end
            end else if (w_sat) begin
               // Signal lost: drop lock and restart from IDLE; period keeps its last value.
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_first   <= 1'b1;
               r_locked  <= 1'b0;
               r_timeout <= 1'b1;
`ifdef FM_DEMOD_AVG_EN
               r_acc     <= '0;
               r_avg_cnt <= '0;
`endif
            end else begin
               if (!r_first) begin
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
               end
               case (r_state)
                  ST_IDLE: begin
                     if (w_below) begin
                        r_state <= ST_ARMED;
                        r_first <= 1'b1;
                     end
                  end
                  ST_HIGH: begin
                     if (w_below) begin
                        r_state <= ST_ARMED;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign period       = r_period;
   assign period_valid = r_period_valid;
   assign locked       = r_locked;
   assign timeout      = r_timeout;
   assign o_dbg_state  = r_state;

endmodule
